// File: rtl/test_processor_assembly.sv
// CPU32 core: single-issue, one instruction-stream word per clock, with a 32x32 register file,
// NZCV condition codes, a reset-cleared data RAM and four 32-bit GPIO groups.
module test_processor_assembly #(
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] lr,
   output logic [31:0] sp,
   output logic [31:0] st,
   output logic [31:0] pc,
   inout  wire  [127:0] pins,
   input  logic [31:0] insn
);
   localparam int AW = $clog2(DMEM_WORDS);

   typedef enum logic [1:0] {S_OP, S_IMM1, S_IMM2} state_t;
   state_t state_reg, state_next;

   logic [31:0] pc_reg, pc_next, ir_reg, addr_reg, imm_reg;
   logic [3:0]  nzcv_reg, nzcv_next;
   logic [31:0] rf_reg   [32];
   logic [31:0] ram_reg  [DMEM_WORDS];
   logic [31:0] gdata_reg [4];
   logic [31:0] gdir_reg  [4];

   logic [31:0] cur, a, b, iaddr, io_rd, r;
   logic [6:0]  op;
   logic [4:0]  s1, s2, d1, d2, wr1_idx;
   logic        uses_imm, f1, f2, last, cond_ok, fire;
   logic [1:0]  nimm;
   logic [2:0]  io_idx;
   logic [32:0] sum;
   logic [63:0] prod;
   logic        wr1_en, wr2_en, ram_we, io_we;
   logic [31:0] wr1_data, wr2_data;
   logic        unused_bit;

   // While immediates are streaming, the opcode word is replayed from ir_reg.
   assign cur        = (state_reg == S_OP) ? insn : ir_reg;
   assign unused_bit = cur[0];
   assign op = cur[31:25];
   assign s1 = cur[20:16];
   assign s2 = cur[15:11];
   assign d1 = cur[10:6];
   assign d2 = cur[5:1];
   assign uses_imm = (op == 7'd6)  || (op == 7'd12) || (op == 7'd14) || (op == 7'd25) ||
                     (op == 7'd26) || (op == 7'd27) || (op == 7'd29) || (op == 7'd30) ||
                     (op == 7'd31) || (op == 7'd32) || (op == 7'd33);
   assign f1    = uses_imm & cur[5];
   assign f2    = uses_imm & cur[4];
   assign nimm  = {1'b0, f1} + {1'b0, f2};
   assign last  = ((state_reg == S_OP) && (nimm == 2'd0)) ||
                  ((state_reg == S_IMM1) && (nimm == 2'd1)) || (state_reg == S_IMM2);
   assign a     = f1 ? ((state_reg == S_IMM2) ? imm_reg : insn) : rf_reg[s1];
   assign b     = f2 ? insn : rf_reg[s2];
   assign iaddr = (state_reg == S_OP) ? pc_reg : addr_reg;
   assign sum   = {1'b0, a} + {1'b0, b};
   assign prod  = {32'd0, a} * {32'd0, b};
   assign io_idx = a[2:0] - 3'd4;
   assign fire  = last & cond_ok;

   assign pc = pc_reg;
   assign lr = rf_reg[29];
   assign sp = rf_reg[30];
   assign st = {nzcv_reg, 28'd0};

   always_comb begin
      cond_ok = 1'b0;
      case (cur[24:21])
         4'h0: cond_ok = nzcv_reg[2];
         4'h1: cond_ok = !nzcv_reg[2];
         4'h2: cond_ok = nzcv_reg[1];
         4'h3: cond_ok = !nzcv_reg[1];
         4'h4: cond_ok = nzcv_reg[3];
         4'h5: cond_ok = !nzcv_reg[3];
         4'h6: cond_ok = nzcv_reg[0];
         4'h7: cond_ok = !nzcv_reg[0];
         4'h8: cond_ok = nzcv_reg[1] && !nzcv_reg[2];
         4'h9: cond_ok = !nzcv_reg[1] || nzcv_reg[2];
         4'hA: cond_ok = nzcv_reg[3] == nzcv_reg[0];
         4'hB: cond_ok = nzcv_reg[3] != nzcv_reg[0];
         4'hC: cond_ok = !nzcv_reg[2] && (nzcv_reg[3] == nzcv_reg[0]);
         4'hD: cond_ok = nzcv_reg[2] || (nzcv_reg[3] != nzcv_reg[0]);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      io_rd = 32'd0;
      if (a >= 32'd8 && a <= 32'd11)
         io_rd = pins[{a[1:0], 5'd0} +: 32];
      else if (a >= 32'd12 && a <= 32'd19)
         io_rd = io_idx[0] ? gdir_reg[io_idx[2:1]] : gdata_reg[io_idx[2:1]];
   end

   always_comb begin
      state_next = S_OP;
      case (state_reg)
         S_OP:    state_next = (nimm != 2'd0) ? S_IMM1 : S_OP;
         S_IMM1:  state_next = (nimm == 2'd2) ? S_IMM2 : S_OP;
         default: state_next = S_OP;
      endcase
      pc_next   = pc_reg + 32'd1;
      nzcv_next = nzcv_reg;
      r         = 32'd0;
      wr1_en    = 1'b0;
      wr1_idx   = d1;
      wr1_data  = 32'd0;
      wr2_en    = 1'b0;
      wr2_data  = 32'd0;
      ram_we    = 1'b0;
      io_we     = 1'b0;
      if (fire) begin
         case (op)
            7'd6:  begin r = a ^ b; wr1_en = 1'b1; wr1_data = r; end
            7'd12: begin
               r = 32'({a, a} >> b[4:0]);
               wr1_en = 1'b1; wr1_data = r;
            end
            7'd14: begin
               r = sum[31:0]; wr1_en = 1'b1; wr1_data = r;
               nzcv_next[1] = sum[32];
               nzcv_next[0] = (a[31] == b[31]) && (r[31] != a[31]);
            end
            7'd18: begin
               r = prod[63:32];
               wr1_en = 1'b1; wr1_data = prod[31:0];
               wr2_en = 1'b1; wr2_data = prod[63:32];
            end
            7'd25: pc_next = a;
            7'd26: pc_next = iaddr + a;
            7'd27: begin
               pc_next = a; wr1_en = 1'b1; wr1_idx = 5'd29; wr1_data = pc_reg + 32'd1;
            end
            7'd28: pc_next = rf_reg[29];
            7'd29: begin wr1_en = 1'b1; wr1_data = ram_reg[a[AW-1:0]]; end
            7'd30: ram_we = 1'b1;
            7'd31: begin wr1_en = 1'b1; wr1_data = io_rd; end
            7'd32: io_we = (a >= 32'd12) && (a <= 32'd19);
            7'd33: begin r = a; wr1_en = 1'b1; wr1_data = a; end
            7'd34: begin
               wr1_en = 1'b1; wr1_data = a;
               wr2_en = 1'b1; wr2_data = b;
            end
            default: ;
         endcase
         // Logic ops report N/Z on their result; mul uses the high word held in r.
         if (op == 7'd6 || op == 7'd12 || op == 7'd14 || op == 7'd18 || op == 7'd33) begin
            nzcv_next[3] = r[31];
            nzcv_next[2] = (r == 32'd0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= S_OP;
      else      state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg   <= 32'd0;
         ir_reg   <= 32'd0;
         addr_reg <= 32'd0;
         imm_reg  <= 32'd0;
         nzcv_reg <= 4'd0;
         for (int i = 0; i < 32; i++) rf_reg[i] <= 32'd0;
         for (int i = 0; i < DMEM_WORDS; i++) ram_reg[i] <= 32'd0;
         for (int i = 0; i < 4; i++) begin
            gdata_reg[i] <= 32'd0;
            gdir_reg[i]  <= 32'd0;
         end
      end else begin
         pc_reg   <= pc_next;
         nzcv_reg <= nzcv_next;
         if (state_reg == S_OP) begin
            ir_reg   <= insn;
            addr_reg <= pc_reg;
         end
         if (state_reg == S_IMM1) imm_reg <= insn;
         // d2 is written last so it wins when both destinations coincide.
         if (wr1_en) rf_reg[wr1_idx] <= wr1_data;
         if (wr2_en) rf_reg[d2] <= wr2_data;
         if (ram_we) ram_reg[a[AW-1:0]] <= b;
         if (io_we) begin
            if (io_idx[0]) gdir_reg[io_idx[2:1]]  <= b;
            else           gdata_reg[io_idx[2:1]] <= b;
         end
      end
   end

   for (genvar gi = 0; gi < 128; gi++) begin : g_pin
      assign pins[gi] = gdir_reg[gi / 32][gi % 32] ? gdata_reg[gi / 32][gi % 32] : 1'bz;
   end
endmodule

// File: tb/tb_test_processor_assembly.sv
// Bench for the CPU32 core: the bench acts as the instruction ROM, an instruction-level model
// predicts architectural state after every instruction, and a monitor checks it cycle by cycle.
module tb_test_processor_assembly;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] lr, sp, st, pc, insn;
   wire  [127:0] pins;
   logic        ext_en = 1'b0;
   logic [31:0] ext_val = 32'd0;
   logic [31:0] rom [512];

   assign pins[31:0] = ext_en ? ext_val : 32'bz;
   assign insn = (pc < 32'd512) ? rom[pc[8:0]] : 32'd0;
   always #5 clk = ~clk;

   test_processor_assembly #(.DMEM_WORDS(64)) dut (
      .clk(clk), .rst(rst), .lr(lr), .sp(sp), .st(st), .pc(pc), .pins(pins), .insn(insn)
   );

   typedef struct {
      int          cyc;
      logic [31:0] pc, lr, sp, st, pmask, pval;
   } exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0, cyc, pushed;

   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;

   // Instruction-level reference state
   logic [31:0] m_r [32];
   logic [31:0] m_ram [64];
   logic [31:0] m_dat [4];
   logic [31:0] m_dir [4];
   logic        m_n, m_z, m_c, m_v;
   logic [31:0] m_pc;
   int          m_cyc;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(int op, int cond, int s1, int s2, int d1, logic [4:0] lo);
      return {7'(op), 4'(cond), 5'(s1), 5'(s2), 5'(d1), lo, 1'b0};
   endfunction

   function automatic bit has_imm(int op);
      return op inside {6, 12, 14, 25, 26, 27, 29, 30, 31, 32, 33};
   endfunction

   function automatic logic [31:0] rom_rd(logic [31:0] addr);
      return (addr < 32'd512) ? rom[addr[8:0]] : 32'd0;
   endfunction

   function automatic bit cond_ok(int c);
      case (c)
         0: return m_z;            1: return !m_z;
         2: return m_c;            3: return !m_c;
         4: return m_n;            5: return !m_n;
         6: return m_v;            7: return !m_v;
         8: return m_c && !m_z;    9: return !m_c || m_z;
         10: return m_n == m_v;    11: return m_n != m_v;
         12: return !m_z && (m_n == m_v);
         13: return m_z || (m_n != m_v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] io_read(logic [31:0] addr);
      int g;
      logic [31:0] ext;
      if (addr >= 8 && addr <= 11) begin
         g = int'(addr) - 8;
         ext = (g == 0 && ext_en) ? ext_val : 32'd0;
         return (m_dat[g] & m_dir[g]) | (ext & ~m_dir[g]);
      end
      if (addr >= 12 && addr <= 19) begin
         g = int'(addr) - 12;
         return (g % 2 == 1) ? m_dir[g / 2] : m_dat[g / 2];
      end
      return 32'd0;
   endfunction

   function automatic void set_nz(logic [31:0] v);
      m_n = v[31];
      m_z = (v == 0);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_r[i] = 0;
      for (int i = 0; i < 64; i++) m_ram[i] = 0;
      for (int i = 0; i < 4; i++) begin m_dat[i] = 0; m_dir[i] = 0; end
      {m_n, m_z, m_c, m_v} = 4'b0;
      m_pc = 0;
      m_cyc = 0;
   endfunction

   function automatic void model_step();
      logic [31:0] w, a, b, ia, nxt, r;
      logic [63:0] p;
      int op, n, g, s1, s2, d1, d2;
      bit f1, f2;
      exp_t e;
      w  = rom_rd(m_pc);
      op = int'(w[31:25]);
      s1 = int'(w[20:16]); s2 = int'(w[15:11]); d1 = int'(w[10:6]); d2 = int'(w[5:1]);
      f1 = has_imm(op) && w[5];
      f2 = has_imm(op) && w[4];
      ia = m_pc;
      nxt = m_pc + 1;
      a = m_r[s1];
      b = m_r[s2];
      if (f1) begin a = rom_rd(nxt); nxt = nxt + 1; end
      if (f2) begin b = rom_rd(nxt); nxt = nxt + 1; end
      m_cyc += 1 + int'(f1) + int'(f2);
      m_pc = nxt;
      if (cond_ok(int'(w[24:21]))) begin
         case (op)
            6:  begin r = a ^ b; m_r[d1] = r; set_nz(r); end
            12: begin
               n = int'(b % 32);
               r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
               m_r[d1] = r; set_nz(r);
            end
            14: begin
               p = 64'(a) + 64'(b);
               r = p[31:0];
               m_r[d1] = r; set_nz(r);
               m_c = (p > 64'hFFFF_FFFF);
               m_v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            18: begin
               p = 64'(a) * 64'(b);
               m_r[d1] = p[31:0]; m_r[d2] = p[63:32];
               set_nz(p[63:32]);
            end
            25: m_pc = a;
            26: m_pc = ia + a;
            27: begin m_r[29] = nxt; m_pc = a; end
            28: m_pc = m_r[29];
            29: m_r[d1] = m_ram[a % 64];
            30: m_ram[a % 64] = b;
            31: m_r[d1] = io_read(a);
            32: if (a >= 12 && a <= 19) begin
               g = int'(a) - 12;
               if (g % 2 == 1) m_dir[g / 2] = b;
               else            m_dat[g / 2] = b;
            end
            33: begin m_r[d1] = a; set_nz(a); end
            34: begin m_r[d1] = a; m_r[d2] = b; end
            default: ;
         endcase
      end
      e.cyc = m_cyc; e.pc = m_pc; e.lr = m_r[29]; e.sp = m_r[30];
      e.st = {m_n, m_z, m_c, m_v, 28'd0};
      e.pmask = m_dir[0]; e.pval = m_dat[0] & m_dir[0];
      sb.push_back(e);
      pushed++;
   endfunction

   // Monitor: checks every predicted instruction boundary when the DUT reaches it.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("commit_cycle", 32'(cyc), 32'(e.cyc));
            check("pc", pc, e.pc);
            check("lr", lr, e.lr);
            check("sp", sp, e.sp);
            check("st", st, e.st);
            check("pins_g0", pins[31:0] & e.pmask, e.pval);
         end
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 512; i++) rom[i] = 32'd0;
   endtask

   // Runs the loaded ROM from reset; rst must be low on entry and is left low.
   task automatic run_prog(string name, int budget);
      repeat (2) @(negedge clk);
      check("reset_pc", pc, 32'd0);
      check("reset_lr", lr, 32'd0);
      check("reset_sp", sp, 32'd0);
      check("reset_st", st, 32'd0);
      model_reset();
      pushed = 0;
      while (m_cyc < budget) model_step();
      @(negedge clk);
      rst = 1'b1;
      repeat (budget + 4) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      rst = 1'b0;
      $display("program %s: %0d instructions predicted over %0d cycles", name, pushed, budget);
   endtask

   task automatic gen_random(output int budget);
      logic [31:0] oaddr [11] = '{32'hC, 32'hD, 32'hE, 32'hF, 32'h10, 32'h11, 32'h12, 32'h13,
                                  32'h0, 32'h8, 32'h20};
      logic [31:0] iaddr [12] = '{32'hC, 32'hD, 32'hE, 32'hF, 32'h10, 32'h11, 32'h12, 32'h13,
                                  32'h0, 32'h7, 32'h14, 32'h100};
      int ops [12] = '{6, 12, 14, 18, 29, 30, 31, 32, 33, 34, 0, 5};
      int p, op, cond, d1, d2;
      logic [1:0] f;
      p = 0;
      for (int i = 0; i < 32; i++) begin
         op   = ops[$urandom_range(0, 11)];
         cond = ($urandom_range(0, 1) == 1) ? 14 : int'($urandom_range(0, 15));
         d1   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(29, 30)) : int'($urandom_range(0, 31));
         d2   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(29, 30)) : int'($urandom_range(0, 31));
         f    = 2'($urandom_range(0, 3));
         if (op == 31 || op == 32) f[1] = 1'b1;
         rom[p] = enc(op, cond, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), d1,
                      has_imm(op) ? {f, 3'($urandom_range(0, 7))} : 5'(d2));
         p++;
         if (has_imm(op) && f[1]) begin
            if (op == 31)      rom[p] = iaddr[$urandom_range(0, 11)];
            else if (op == 32) rom[p] = oaddr[$urandom_range(0, 10)];
            else rom[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            p++;
         end
         if (has_imm(op) && f[0]) begin
            rom[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            p++;
         end
      end
      budget = p + 4;
   endtask

   initial begin : stimulus
      int budget;
      clear_rom();
      repeat (3) @(negedge clk);

      // Directed program: movs, add imm+imm, brl/ret, conditions, str/ldr, in from pins
      rom[0]   = 32'h43C007A0;                     rom[1] = 32'h00014888;
      rom[2]   = enc(14, 14, 0, 0, 29, 5'b11000);  rom[3] = 32'h00035942; rom[4] = 32'hDEADBEAF;
      rom[5]   = enc(33, 14, 0, 0, 6, 5'b10000);   rom[6] = 32'h100;
      rom[16]  = enc(27, 14, 6, 0, 0, 5'b00000);
      rom[256] = enc(33, 14, 0, 0, 7, 5'b10000);   rom[257] = 32'h80000000;
      rom[258] = enc(25, 5, 0, 0, 0, 5'b10000);    rom[259] = 32'h50;
      rom[260] = enc(28, 4, 0, 0, 0, 5'b00000);
      rom[17]  = enc(30, 14, 0, 0, 0, 5'b11000);   rom[18] = 32'd16; rom[19] = 32'hCAFEF00D;
      rom[20]  = enc(29, 14, 0, 0, 30, 5'b10000);  rom[21] = 32'd16;
      rom[22]  = enc(31, 14, 0, 0, 29, 5'b10000);  rom[23] = 32'h8;
      rom[24]  = enc(25, 14, 0, 0, 0, 5'b00000);
      ext_en = 1'b1;
      ext_val = 32'h00001488;
      run_prog("directed", 60);
      ext_en = 1'b0;

      // Fibonacci on GPIO group 0 until the first carry, then br r0
      clear_rom();
      rom[0]  = enc(32, 14, 0, 0, 0, 5'b11000);  rom[1] = 32'hD; rom[2] = 32'hFFFFFFFF;
      rom[3]  = enc(33, 14, 0, 0, 1, 5'b10000);  rom[4] = 32'd1;
      rom[5]  = enc(33, 14, 0, 0, 4, 5'b10000);  rom[6] = 32'hC;
      rom[7]  = enc(14, 14, 1, 2, 3, 5'b00000);
      rom[8]  = enc(34, 14, 3, 1, 1, 5'd2);
      rom[9]  = enc(32, 3, 4, 1, 0, 5'b00000);
      rom[10] = enc(26, 3, 0, 0, 0, 5'b10000);   rom[11] = 32'hFFFFFFFD;
      rom[12] = enc(25, 14, 0, 0, 0, 5'b00000);
      run_prog("fibonacci", 400);

      for (int k = 0; k < 3; k++) begin
         clear_rom();
         gen_random(budget);
         run_prog($sformatf("random%0d", k), budget);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
